// File: rtl/matvec_ctrl_pkg.sv
// Shared definitions for the matrix-vector controller: FSM encoding and width helpers.
package matvec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int calc_bitwidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

endpackage

// File: rtl/matvec_ctrl_if.sv
// Bundle of the controller's command, weight-stream, weight-RAM, engine and result signals.
interface matvec_ctrl_if
    import matvec_ctrl_pkg::*;
#(
    parameter int NROW          = 16,
    parameter int NCOL          = 4,
    parameter int BITWIDTH      = calc_bitwidth(6, 11),
    parameter int ADDR_BITWIDTH = log2_ceil(4)
);
    logic                         start;
    logic                         load_w;
    logic [BITWIDTH*NCOL-1:0]     x_vec;
    logic                         w_valid;
    logic                         w_ready;
    logic [BITWIDTH*NROW-1:0]     w_data;
    logic                         wram_we;
    logic [ADDR_BITWIDTH-1:0]     wram_waddr;
    logic [BITWIDTH*NROW-1:0]     wram_wdata;
    logic                         dp_reset;
    logic [ADDR_BITWIDTH-1:0]     dp_col_addr;
    logic [BITWIDTH-1:0]          dp_input;
    logic                         dp_ready;
    logic [BITWIDTH*NROW-1:0]     dp_out;
    logic [BITWIDTH*NROW-1:0]     result;
    logic                         result_valid;
    logic                         result_ready;
    logic                         busy;
    logic                         error;

    modport master (
        input  start, load_w, x_vec, w_valid, w_data, dp_col_addr, dp_ready, dp_out, result_ready,
        output w_ready, wram_we, wram_waddr, wram_wdata, dp_reset, dp_input,
               result, result_valid, busy, error
    );

    modport slave (
        output start, load_w, x_vec, w_valid, w_data, dp_col_addr, dp_ready, dp_out, result_ready,
        input  w_ready, wram_we, wram_waddr, wram_wdata, dp_reset, dp_input,
               result, result_valid, busy, error
    );
endinterface

// File: rtl/matvec_ctrl.sv
// Sequences optional weight load, dot-product run and result hand-off; RUN starts 1 cycle after
// start or the last weight beat. w_valid low stalls LOAD; result_ready low holds HOLD indefinitely.
module matvec_ctrl
    import matvec_ctrl_pkg::*;
#(
    parameter int NROW        = 16,
    parameter int NCOL        = 4,
    parameter int QN          = 6,
    parameter int QM          = 11,
    parameter int RUN_TIMEOUT = 1024
) (
    input  logic             clock,
    input  logic             reset,
    matvec_ctrl_if.master    bus
);
    localparam int BITWIDTH      = calc_bitwidth(QN, QM);
    localparam int ADDR_BITWIDTH = log2_ceil(NCOL);
    localparam int CNT_W         = log2_ceil(RUN_TIMEOUT + 1);
    localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(NCOL - 1);

    state_e                      state_q, state_d;
    logic [ADDR_BITWIDTH-1:0]    col_q, col_d;
    logic [CNT_W-1:0]            run_cnt_q, run_cnt_d;
    logic                        rdy_prev_q, rdy_prev_d;
    logic [BITWIDTH*NCOL-1:0]    x_q, x_d;
    logic [BITWIDTH*NROW-1:0]    result_q, result_d;
    logic                        error_q, error_d;
    logic                        w_beat;

    // Handshake outputs are masked by reset so a beat in the reset cycle never lands.
    assign w_beat = (state_q == ST_LOAD) && bus.w_valid && !reset;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        run_cnt_d  = run_cnt_q;
        rdy_prev_d = 1'b1;
        x_d        = x_q;
        result_d   = result_q;
        error_d    = error_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    x_d       = bus.x_vec;
                    error_d   = 1'b0;
                    col_d     = '0;
                    run_cnt_d = '0;
                    state_d   = bus.load_w ? ST_LOAD : ST_RUN;
                end
            end
            ST_LOAD: begin
                if (w_beat) begin
                    col_d = col_q + ADDR_BITWIDTH'(1);
                    if (col_q == LAST_COL) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Previous-ready is forced high outside RUN, so a level already high on entry is no edge.
                rdy_prev_d = bus.dp_ready;
                if (bus.dp_ready && !rdy_prev_q) begin
                    result_d = bus.dp_out;
                    state_d  = ST_HOLD;
                end else if (run_cnt_q == CNT_W'(RUN_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    run_cnt_d = run_cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (bus.result_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            run_cnt_q  <= '0;
            rdy_prev_q <= 1'b1;
            x_q        <= '0;
            result_q   <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            run_cnt_q  <= run_cnt_d;
            rdy_prev_q <= rdy_prev_d;
            x_q        <= x_d;
            result_q   <= result_d;
            error_q    <= error_d;
        end
    end

    assign bus.w_ready      = (state_q == ST_LOAD) && !reset;
    assign bus.wram_we      = w_beat;
    assign bus.wram_waddr   = col_q;
    assign bus.wram_wdata   = bus.w_data;
    assign bus.dp_reset     = (state_q != ST_RUN);
    assign bus.dp_input     = (state_q == ST_RUN) ?
                              x_q[int'(bus.dp_col_addr) * BITWIDTH +: BITWIDTH] : '0;
    assign bus.result       = result_q;
    assign bus.result_valid = (state_q == ST_HOLD) && !reset;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.error        = error_q;

endmodule

// File: tb/tb_matvec_ctrl.sv
// Randomized bench: a behavioural dot-product engine and weight RAM around the controller,
// with results compared against a plain-arithmetic matrix-vector reference.
module tb_matvec_ctrl;
    localparam int NR          = 16;
    localparam int NC          = 4;
    localparam int QN          = 6;
    localparam int QM          = 11;
    localparam int RUN_TIMEOUT = 1024;
    localparam int BW          = QN + QM + 1;
    localparam int AW          = 2;
    localparam logic [BW-1:0] ONE = 18'h00800;

    typedef logic [BW*NR-1:0] col_t;
    typedef logic [BW*NC-1:0] xvec_t;

    logic clock = 1'b0;
    logic reset;

    matvec_ctrl_if #(.NROW(NR), .NCOL(NC), .BITWIDTH(BW), .ADDR_BITWIDTH(AW)) bus();

    matvec_ctrl #(.NROW(NR), .NCOL(NC), .QN(QN), .QM(QM), .RUN_TIMEOUT(RUN_TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    int      checks = 0;
    int      errors = 0;
    col_t    ref_w [NC];
    col_t    w_mem [NC];
    int      waddr_log [$];
    int      eng_mode = 0;
    int      eng_cnt;
    logic [BW-1:0] acc [NR];
    col_t    exp_result;

    task automatic check_eq(input string tag, input logic [BW*NR-1:0] got, input logic [BW*NR-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [BW-1:0] mulq(input logic [BW-1:0] a, input logic [BW-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> QM;
        return p[BW-1:0];
    endfunction

    function automatic col_t ref_matvec(input xvec_t x);
        col_t   res;
        longint sum, p;
        res = '0;
        for (int r = 0; r < NR; r++) begin
            sum = 0;
            for (int c = 0; c < NC; c++) begin
                p = longint'($signed(ref_w[c][r*BW +: BW])) * longint'($signed(x[c*BW +: BW]));
                sum += (p >>> QM);
            end
            res[r*BW +: BW] = sum[BW-1:0];
        end
        return res;
    endfunction

    function automatic logic [BW-1:0] rnd_q();
        int v;
        v = int'($urandom_range(0, 8191)) - 4096;
        return v[BW-1:0];
    endfunction

    function automatic xvec_t rnd_x();
        xvec_t x;
        for (int c = 0; c < NC; c++) x[c*BW +: BW] = rnd_q();
        return x;
    endfunction

    task automatic rnd_weights();
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++) ref_w[c][r*BW +: BW] = rnd_q();
    endtask

    // Weight RAM and engine model; walks columns in descending order to exercise dp_col_addr.
    initial begin
        bus.dp_col_addr = AW'(NC - 1);
        bus.dp_ready    = 1'b0;
        bus.dp_out      = '0;
        eng_cnt         = 0;
        forever begin
            @(negedge clock);
            if (bus.wram_we === 1'b1) begin
                w_mem[bus.wram_waddr] = bus.wram_wdata;
                waddr_log.push_back(int'(bus.wram_waddr));
            end
            if (eng_mode == 1) begin
                bus.dp_ready = 1'b0;
                bus.dp_out   = {NR{18'h2AAAA}};
            end else if (eng_mode == 2) begin
                bus.dp_ready = 1'b1;
                bus.dp_out   = {NR{18'h15555}};
            end else if (bus.dp_reset !== 1'b0) begin
                eng_cnt         = 0;
                bus.dp_col_addr = AW'(NC - 1);
                bus.dp_ready    = 1'b0;
                bus.dp_out      = '0;
                for (int r = 0; r < NR; r++) acc[r] = '0;
            end else if (eng_cnt < NC) begin
                for (int r = 0; r < NR; r++)
                    acc[r] = acc[r] + mulq(w_mem[bus.dp_col_addr][r*BW +: BW], bus.dp_input);
                eng_cnt++;
                bus.dp_col_addr = AW'(NC - 1 - eng_cnt);
            end else begin
                bus.dp_ready = 1'b1;
                for (int r = 0; r < NR; r++) bus.dp_out[r*BW +: BW] = acc[r];
            end
        end
    end

    task automatic check_reset(input string pfx);
        check_eq({pfx, "_busy"}, bus.busy, 0);
        check_eq({pfx, "_result"}, bus.result, 0);
        check_eq({pfx, "_rvld"}, bus.result_valid, 0);
        check_eq({pfx, "_error"}, bus.error, 0);
        check_eq({pfx, "_wrdy"}, bus.w_ready, 0);
        check_eq({pfx, "_we"}, bus.wram_we, 0);
        check_eq({pfx, "_dprst"}, bus.dp_reset, 1);
        check_eq({pfx, "_dpin"}, bus.dp_input, 0);
    endtask

    task automatic start_op(input bit lw, input xvec_t x, input int gap_at, input int gap_len, input int beats);
        waddr_log.delete();
        bus.start  = 1'b1;
        bus.load_w = lw;
        bus.x_vec  = x;
        tick();
        bus.start  = 1'b0;
        bus.load_w = 1'b0;
        check_eq("start_err_clr", bus.error, 0);
        if (!lw) begin
            check_eq("lat_start", bus.dp_reset, 0);
        end else begin
            for (int b = 0; b < beats; b++) begin
                if (b == gap_at) begin
                    bus.w_valid = 1'b0;
                    repeat (gap_len) tick();
                end
                bus.w_valid = 1'b1;
                bus.w_data  = ref_w[b];
                tick();
            end
            bus.w_valid = 1'b0;
            if (beats == NC) check_eq("lat_load", bus.dp_reset, 0);
        end
    endtask

    task automatic wait_done(output int run_cycles);
        run_cycles = 0;
        for (int i = 0; i < 3000 && bus.result_valid !== 1'b1 && bus.busy === 1'b1; i++) begin
            if (bus.dp_reset === 1'b0) run_cycles++;
            tick();
        end
    endtask

    task automatic check_waddr(input int n);
        check_eq("waddr_n", waddr_log.size(), n);
        for (int i = 0; i < waddr_log.size() && i < n; i++) check_eq("waddr", waddr_log[i], i);
    endtask

    task automatic ack(input int hold, input bit poke_start);
        for (int i = 0; i < hold; i++) begin
            check_eq("hold_vld", bus.result_valid, 1);
            check_eq("hold_res", bus.result, exp_result);
            bus.start  = poke_start;
            bus.load_w = 1'b1;
            tick();
        end
        check_eq("hold_vld", bus.result_valid, 1);
        check_eq("hold_wrdy", bus.w_ready, 0);
        bus.start        = 1'b0;
        bus.load_w       = 1'b0;
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        check_eq("ack_idle", bus.busy, 0);
        check_eq("ack_vld", bus.result_valid, 0);
    endtask

    task automatic run_checked(input bit lw, input xvec_t x, input int gap_at, input int gap_len);
        int   rc;
        col_t exp;
        exp = ref_matvec(x);
        start_op(lw, x, gap_at, gap_len, NC);
        wait_done(rc);
        check_eq("result_vld", bus.result_valid, 1);
        check_waddr(lw ? NC : 0);
        check_eq("result", bus.result, exp);
        exp_result = exp;
    endtask

    task automatic run_timeout(input int mode);
        int rc;
        eng_mode = mode;
        start_op(1'b0, rnd_x(), -1, 0, 0);
        wait_done(rc);
        check_eq("tmo_cycles", rc, RUN_TIMEOUT);
        check_eq("tmo_error", bus.error, 1);
        check_eq("tmo_busy", bus.busy, 0);
        check_eq("tmo_result", bus.result, exp_result);
        eng_mode = 0;
    endtask

    initial begin
        xvec_t x;
        reset            = 1'b1;
        bus.start        = 1'b1;
        bus.load_w       = 1'b1;
        bus.x_vec        = '0;
        bus.w_valid      = 1'b1;
        bus.w_data       = '0;
        bus.result_ready = 1'b1;
        exp_result       = '0;
        repeat (3) tick();
        check_reset("por");
        reset            = 1'b0;
        bus.start        = 1'b0;
        bus.load_w       = 1'b0;
        bus.w_valid      = 1'b0;
        bus.result_ready = 1'b0;
        tick();

        // All-ones weights and input: every row sums to 4.0.
        for (int c = 0; c < NC; c++) ref_w[c] = {NR{ONE}};
        run_checked(1'b1, {NC{ONE}}, -1, 0);
        check_eq("ones_rows", bus.result, {NR{18'h02000}});
        ack(0, 1'b0);

        // Reuse stored weights with a single 2.0 element; HOLD ignores start for 5 cycles.
        x = '0;
        x[0 +: BW] = 18'h01000;
        run_checked(1'b0, x, -1, 0);
        check_eq("reuse_rows", bus.result, {NR{18'h01000}});
        ack(5, 1'b1);

        // Weight stream stall of 3 cycles between beats 1 and 2.
        rnd_weights();
        run_checked(1'b1, rnd_x(), 2, 3);
        ack(1, 1'b0);

        for (int it = 0; it < 6; it++) begin
            bit lw;
            lw = (it % 3 == 0) || ($urandom_range(0, 1) == 1);
            if (lw) rnd_weights();
            run_checked(lw, rnd_x(), int'($urandom_range(0, NC)), int'($urandom_range(0, 4)));
            ack(int'($urandom_range(0, 3)), 1'(($urandom_range(0, 1))));
        end

        run_timeout(1);
        run_timeout(2);

        run_checked(1'b0, rnd_x(), -1, 0);
        ack(0, 1'b0);

        // Reset lands mid-LOAD with a third beat, start and ack all presented.
        rnd_weights();
        x = rnd_x();
        start_op(1'b1, x, -1, 0, 2);
        reset            = 1'b1;
        bus.start        = 1'b1;
        bus.load_w       = 1'b1;
        bus.w_valid      = 1'b1;
        bus.w_data       = ref_w[2];
        bus.result_ready = 1'b1;
        tick();
        check_reset("mid");
        check_eq("rst_writes", waddr_log.size(), 2);
        reset            = 1'b0;
        bus.start        = 1'b0;
        bus.load_w       = 1'b0;
        bus.w_valid      = 1'b0;
        bus.result_ready = 1'b0;
        exp_result       = '0;
        tick();
        run_checked(1'b1, x, -1, 0);
        ack(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/matvec_ctrl.md
MATVEC_CTRL -- requirements
Module: matvec_ctrl

Interface
REQ-001 Parameter NROW, default 16: number of output rows.
REQ-002 Parameter NCOL, default 4: number of input columns; power of two, at least 2.
REQ-003 Parameter QN, default 6: integer bits. Parameter QM, default 11: fraction bits. BITWIDTH = QN+QM+1. ADDR_BITWIDTH = log2(NCOL).
REQ-004 Parameter RUN_TIMEOUT, default 1024: maximum RUN cycles before abort.
REQ-005 Port clock, input, 1: clock; all logic on the rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port start, input, 1: request one matrix-vector operation.
REQ-008 Port load_w, input, 1: sampled with start; 1 = reload weights first, 0 = reuse stored weights.
REQ-009 Port x_vec, input, BITWIDTH*NCOL: input vector, sampled with start; element c occupies [c*BITWIDTH +: BITWIDTH].
REQ-010 Ports w_valid in 1, w_ready out 1, w_data in BITWIDTH*NROW: weight column stream, one column per beat.
REQ-011 Ports wram_we out 1, wram_waddr out ADDR_BITWIDTH, wram_wdata out BITWIDTH*NROW: weight RAM write side.
REQ-012 Ports dp_reset out 1, dp_col_addr in ADDR_BITWIDTH, dp_input out BITWIDTH, dp_ready in 1, dp_out in BITWIDTH*NROW: dot-product engine side.
REQ-013 Ports result out BITWIDTH*NROW, result_valid out 1, result_ready in 1: result handshake.
REQ-014 Ports busy out 1 and error out 1: status outputs.

Function
REQ-015 The FSM SHALL have four states: IDLE, LOAD, RUN, HOLD.
REQ-016 In IDLE, start=1 SHALL latch x_vec, clear error, and enter LOAD if load_w=1, else RUN; start SHALL be ignored outside IDLE.
REQ-017 In LOAD, w_ready SHALL be 1; each w_valid&&w_ready beat SHALL write column counter c: wram_we=1, wram_waddr=c, wram_wdata=w_data, all combinational from the same cycle.
REQ-018 The column counter SHALL clear on entry to LOAD; the beat with c=NCOL-1 SHALL move the FSM to RUN the next cycle; w_valid=0 stalls without timeout.
REQ-019 dp_reset SHALL be 1 in IDLE, LOAD and HOLD, and 0 only in RUN.
REQ-020 dp_input SHALL be combinational: latched element at index dp_col_addr in RUN, otherwise zero.
REQ-021 In RUN, a dp_ready 0->1 edge (registered previous value) SHALL capture dp_out into result and enter HOLD; a level-high dp_ready on RUN entry SHALL NOT count.
REQ-022 A RUN cycle counter SHALL reach RUN_TIMEOUT without a capture, then set error=1 (sticky until the next accepted start) and return to IDLE with result unchanged.
REQ-023 In HOLD, result_valid SHALL be 1; result_valid&&result_ready SHALL return the FSM to IDLE the next cycle; result SHALL hold until the next capture.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Latency from start (load_w=0) to dp_reset=0 SHALL be 1 cycle. From the last weight beat to dp_reset=0 SHALL be 1 cycle.

Reset
REQ-026 reset SHALL dominate start and all handshakes in the same cycle, and SHALL take effect mid-operation from any state.
REQ-027 On reset: state=IDLE, counters=0, result=0, result_valid=0, error=0, busy=0, w_ready=0, wram_we=0, dp_reset=1, dp_input=0.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the BITWIDTH/ADDR_BITWIDTH derivations, and the log2 function.
REQ-029 No sub-module SHALL be used; the block is a single FSM with counters.

Verification
REQ-030 Defaults; weights all 18'h00800 (1.0); x all 1.0; start with load_w=1 -> 4 LOAD beats, addr 0..3, then every result row = 18'h02000 (4.0).
REQ-031 start with load_w=0 and x = {2.0,0,0,0} after REQ-030 -> no wram_we, rows = 18'h01000 (2.0).
REQ-032 w_valid deasserted 3 cycles between beats 1 and 2 -> exactly 4 writes, addr 0..3, result correct.
REQ-033 Engine dp_ready held 0 -> error=1 at RUN cycle 1024, state IDLE, result unchanged.
REQ-034 result_ready held 0 for 5 cycles -> result_valid stays 1 and start is ignored; ack -> IDLE next cycle.
REQ-035 reset during LOAD after 2 beats -> next cycle every REQ-027 value holds; a fresh run writes from addr 0.
